// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift/rotate sequencer.
//   - op_e     : opcode encodings presented on in_op
//   - state_e  : sequencer FSM states
//   - W / CW   : operand width and count width
//   - hi_bit() : highest-set-bit encode used to pick the next stage
package shift_pkg;

  localparam int W  = 16;
  localparam int CW = 4;

  typedef enum logic [1:0] {
    OP_RLL = 2'b00,  // rotate left
    OP_SLL = 2'b01,  // shift left logical
    OP_SRA = 2'b10,  // shift right arithmetic
    OP_SRL = 2'b11   // shift right logical
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Index of the highest set bit of a 4-bit mask; 0 for an empty mask
  // (never used that way, the FSM leaves SHIFT before the mask empties).
  function automatic logic [1:0] hi_bit(input logic [CW-1:0] m);
    logic [1:0] k;
    k = 2'd0;
    if (m[3])      k = 2'd3;
    else if (m[2]) k = 2'd2;
    else if (m[1]) k = 2'd1;
    return k;
  endfunction

endpackage

// File: rtl/shift_seq_if.sv
// Command/result handshake bundle for shift_seq.
//   in_valid/in_ready  : command handshake (in_data, in_cnt, in_op)
//   out_valid/out_ready: result handshake (out_data)
// master = issue side (drives command, consumes result)
// slave  = the sequencer
interface shift_seq_if;
  import shift_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [CW-1:0] in_cnt;
  logic [1:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;

  modport master (
    output in_valid, in_data, in_cnt, in_op, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_cnt, in_op, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/shift_stage.sv
// Single combinational power-of-two shift stage, shared by every cycle of
// the sequencer.
//   data    : stage input operand
//   op      : rotate / logical left / arithmetic right / logical right
//   amt_sel : 0..3 selects a shift of 1, 2, 4 or 8
//   result  : shifted operand
module shift_stage
  import shift_pkg::*;
(
  input  logic [W-1:0] data,
  input  op_e          op,
  input  logic [1:0]   amt_sel,
  output logic [W-1:0] result
);

  logic [4:0] amt;
  logic [4:0] ramt;

  assign amt  = 5'd1 << amt_sel;
  // amt is 1..8, so the complementary rotate distance stays within 8..15
  assign ramt = 5'(W) - amt;

  always_comb begin
    result = data;
    unique case (op)
      OP_RLL: result = (data << amt) | (data >> ramt);
      OP_SLL: result = data << amt;
      // sign comes from this stage's input, so chained stages stay exact
      OP_SRA: result = $unsigned($signed(data) >>> amt);
      OP_SRL: result = data >> amt;
      default: result = data;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Iterative 16-bit shift/rotate sequencer.
// Takes one operand + 4-bit count + opcode, then walks the set count bits
// from highest to lowest, applying the matching 8/4/2/1 stage once per cycle
// through one shared shift_stage. Result is held until the consumer takes it.
//   clk, rst_n : clock, async active-low reset
//   bus        : shift_seq_if.slave (command in, result out)
//   busy       : high while an operation is in SHIFT or DONE
module shift_seq
  import shift_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  shift_seq_if.slave    bus,
  output logic          busy
);

  state_e        state_q, state_n;
  logic [W-1:0]  data_q,  data_n;
  op_e           op_q,    op_n;
  logic [CW-1:0] mask_q,  mask_n;

  logic [1:0]    k;
  logic [CW-1:0] mask_clr;
  logic [W-1:0]  stage_out;

  // Next stage to apply: highest remaining count bit.
  assign k        = hi_bit(mask_q);
  assign mask_clr = mask_q & ~(4'b0001 << k);

  shift_stage u_stage (
    .data    (data_q),
    .op      (op_q),
    .amt_sel (k),
    .result  (stage_out)
  );

  // Handshake outputs decode the state register only; out_data is the data
  // register itself, so nothing on in_* reaches out_* combinationally.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = data_q;
  assign busy          = (state_q == SHIFT) || (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      op_q    <= OP_RLL;
      mask_q  <= '0;
    end else begin
      state_q <= state_n;
      data_q  <= data_n;
      op_q    <= op_n;
      mask_q  <= mask_n;
    end
  end

  always_comb begin
    state_n = state_q;
    data_n  = data_q;
    op_n    = op_q;
    mask_n  = mask_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_n  = bus.in_data;
          op_n    = op_e'(bus.in_op);
          mask_n  = bus.in_cnt;
          // zero count skips SHIFT entirely; operand passes through as-is
          state_n = (bus.in_cnt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        data_n = stage_out;
        mask_n = mask_clr;
        if (mask_clr == '0) state_n = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_seq.sv
module tb_shift_seq;
  import shift_pkg::*;

  logic clk;
  logic rst_n;
  logic busy;

  shift_seq_if bus ();

  shift_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  logic [15:0] sb[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: one shift by the whole count, bit by bit.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] c,
                                            input logic [1:0] o);
    logic [15:0] r;
    int n;
    n = int'(c);
    for (int i = 0; i < 16; i++) begin
      case (o)
        2'b00:   r[i] = d[(i - n + 16) % 16];
        2'b01:   r[i] = (i - n >= 0) ? d[i - n] : 1'b0;
        2'b10:   r[i] = (i + n < 16) ? d[i + n] : d[15];
        default: r[i] = (i + n < 16) ? d[i + n] : 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic send(input logic [15:0] d, input logic [3:0] c, input logic [1:0] o);
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk("in_ready_before_send", 16'(bus.in_ready), 16'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_cnt   = c;
    bus.in_op    = o;
    @(posedge clk); #1;
    // scramble inputs after accept: the captured command must be frozen
    bus.in_valid = 1'b0;
    bus.in_data  = 16'($urandom);
    bus.in_cnt   = 4'($urandom);
    bus.in_op    = 2'($urandom);
  endtask

  // Full operation with out_ready high: checks latency, busy length, result.
  task automatic run_op(input string tag, input logic [15:0] d, input logic [3:0] c,
                        input logic [1:0] o, input logic [15:0] exp);
    int cyc, bcnt;
    sb.push_back(exp);
    send(d, c, o);
    cyc = 0; bcnt = 0;
    while (!bus.out_valid && cyc < 20) begin
      if (busy) bcnt++;
      @(posedge clk); #1; cyc++;
    end
    chk({tag, "_latency"}, 16'(cyc), 16'($countones(c)));
    chk({tag, "_data"}, bus.out_data, sb.pop_front());
    chk({tag, "_busy_done"}, 16'(busy), 16'd1);
    bcnt++;
    @(posedge clk); #1;
    chk({tag, "_in_ready_after"}, 16'(bus.in_ready), 16'd1);
    chk({tag, "_busy_cycles"}, 16'(bcnt), 16'($countones(c) + 1));
  endtask

  initial begin
    int cyc;
    logic [15:0] rd;
    logic [3:0]  rc;
    logic [1:0]  ro;

    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_cnt    = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_out_data", bus.out_data, 16'h0000);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_in_ready", 16'(bus.in_ready), 16'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases
    run_op("rll_1234_8",  16'h1234, 4'd8,  2'b00, 16'h3412);
    run_op("sra_8001_15", 16'h8001, 4'd15, 2'b10, 16'hFFFF);
    run_op("srl_8001_15", 16'h8001, 4'd15, 2'b11, 16'h0001);
    run_op("sll_8001_1",  16'h8001, 4'd1,  2'b01, 16'h0002);
    run_op("srl_8001_4",  16'h8001, 4'd4,  2'b11, 16'h0800);
    run_op("rll_8001_5",  16'h8001, 4'd5,  2'b00, 16'h0030);
    run_op("rll_beef_0",  16'hBEEF, 4'd0,  2'b00, 16'hBEEF);
    run_op("sra_7f00_9",  16'h7F00, 4'd9,  2'b10, 16'h003F);

    // random cases against the reference model
    for (int i = 0; i < 8; i++) begin
      rd = 16'($urandom);
      rc = 4'($urandom);
      ro = 2'($urandom);
      run_op("rand", rd, rc, ro, ref_shift(rd, rc, ro));
    end

    // backpressure: result held for 3 cycles, new command ignored
    bus.out_ready = 1'b0;
    sb.push_back(16'h0002);
    send(16'h8001, 4'd1, 2'b01);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk("bp_latency", 16'(cyc), 16'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hAAAA;
    bus.in_cnt   = 4'd3;
    bus.in_op    = 2'b00;
    for (int i = 0; i < 3; i++) begin
      chk("bp_out_valid", 16'(bus.out_valid), 16'd1);
      chk("bp_out_data", bus.out_data, sb[0]);
      chk("bp_in_ready", 16'(bus.in_ready), 16'd0);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_release_data", bus.out_data, sb.pop_front());
    @(posedge clk); #1;
    chk("bp_idle_in_ready", 16'(bus.in_ready), 16'd1);
    chk("bp_idle_out_valid", 16'(bus.out_valid), 16'd0);
    @(posedge clk); #1;
    chk("bp_no_accept_busy", 16'(busy), 16'd0);

    // reset during the second SHIFT cycle of a full-count operation
    send(16'h5A5A, 4'hF, 2'b11);
    @(posedge clk); #1;
    chk("mid_busy_before_rst", 16'(busy), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("mid_rst_out_data", bus.out_data, 16'h0000);
    chk("mid_rst_busy", 16'(busy), 16'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("mid_rst_in_ready", 16'(bus.in_ready), 16'd1);
    @(posedge clk); #1;
    run_op("post_rst_rll", 16'h00FF, 4'd4, 2'b00, 16'h0FF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
